io_port_responder: RTL
======================

Name: io_port_responder

Overview:
- Device-side responder for the CPU's port interface; sits outside the CPU, opposite its port bus.
- Captures CPU output-port writes (we_o, io_port, out_p0..out_p3) into a tagged FIFO drained by an external consumer.
- Holds one byte per input port for the CPU (in_p0..in_p3), with per-port valid flags on ine_p0..ine_p3.
- Generates the periodic i_timer interrupt pulse.

Parameters:
- FIFO_DEPTH, 8, output-capture FIFO entries; power of two, at least 2.
- TIMER_PERIOD, 1000, clk cycles between i_timer pulses; at least 2.
- TW, 16, timer counter width; TIMER_PERIOD must be below 2^TW.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset (reset=0 resets immediately).
- we_o  in  1  CPU output-port write strobe; one write per cycle high.
- io_port  in  2  port index of the CPU write.
- out_p0..out_p3  in  8 each  CPU output-port data.
- m_valid  out  1  capture FIFO not empty.
- m_ready  in  1  consumer accepts the head entry.
- m_port  out  2  port tag of the head entry.
- m_data  out  8  data of the head entry.
- overflow  out  1  sticky: a CPU write was dropped.
- ovf_clr  in  1  clears overflow.
- s_valid  in  1  producer offers a byte.
- s_port  in  2  target input port.
- s_data  in  8  byte offered.
- s_ready  out  1  target holding register empty.
- in_ack  in  1  CPU consumed an input byte.
- in_ack_port  in  2  port index consumed.
- in_p0..in_p3  out  8 each  input holding registers, to the CPU.
- ine_p0..ine_p3  out  8 each  {7'b0, full_N}, to the CPU.
- timer_en  in  1  timer enable.
- i_timer  out  1  one-cycle interrupt pulse, to the CPU.

Behaviour:
- Reset values:
  - m_valid=0, overflow=0, i_timer=0.
  - in_pN=0 and ine_pN=0.
  - FIFO pointers and count=0; timer counter=0.
  - m_port and m_data read 0 while empty.
- Capture path:
  - When we_o=1, push {io_port, out_p[io_port]} at the clock edge.
  - Head is visible on m_* in the same cycle m_valid=1 (first-word fall-through).
  - Latency from write to m_valid: 1 cycle.
  - Pop occurs when m_valid and m_ready are both 1.
- Full FIFO:
  - A push while full with no pop is dropped and sets overflow.
  - Push and pop in the same cycle while full both take effect; count is unchanged and nothing is dropped.
- Empty FIFO: pop is ignored; no underflow.
- Pointers wrap modulo FIFO_DEPTH.
- overflow clear/set priority: set wins over ovf_clr in the same cycle.
- Input path:
  - s_ready = !full[s_port], combinational.
  - When s_valid and s_ready, load in_p[s_port] = s_data and set full[s_port] next cycle.
  - When in_ack=1, clear full[in_ack_port]; in_p holds its last value.
  - Ack and load to the same port in the same cycle: s_ready is computed from pre-ack state, so the load is refused; the producer retries next cycle.
  - Ack to an empty port has no effect.
- Timer:
  - While timer_en=1, the counter increments each cycle.
  - When the counter reaches TIMER_PERIOD-1, i_timer=1 for exactly one cycle and the counter returns to 0.
  - timer_en=0 holds the counter and forces i_timer=0.
  - Re-enable resumes from the held count.
- Reset mid-operation: all state clears asynchronously. Any in-flight FIFO entries and held bytes are lost, and no spurious i_timer is produced after release.

Test Plan:
- Reset release, then we_o=1 with io_port=2, out_p2=8'hA5 and m_ready=0 → next cycle m_valid=1, m_port=2, m_data=A5. Then m_ready=1 → m_valid=0 the following cycle.
- Nine writes 01..09 with m_ready=0 and FIFO_DEPTH=8 → overflow=1 and count=8. Drain yields 01..08 in order. Assert ovf_clr → overflow=0.
- FIFO full, we_o=1 and m_ready=1 in the same cycle → no overflow and count stays 8. The new byte appears last on drain.
- s_valid with s_port=1, s_data=3C → in_p1=3C and ine_p1=01; s_ready for port 1 drops to 0. in_ack with port 1 → ine_p1=00 and s_ready=1.
- TIMER_PERIOD=5 with timer_en held 1 → i_timer pulses on cycles 5, 10, 15, each one cycle wide. Drop timer_en for 3 cycles mid-count → the next pulse is delayed by 3 cycles.
- Assert reset (0) asynchronously while the FIFO holds 3 entries and full0=1 → m_valid, ine_p0 and overflow go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/io_port_responder.sv
// io_port_responder
//
// Device-side responder that sits opposite the CPU's port bus.
//
// Output-capture path
//   Every CPU output-port write (we_o) is pushed into a tagged FIFO as
//   {io_port, out_p[io_port]}. An external consumer drains the FIFO through a
//   first-word-fall-through valid/ready interface. A write that finds the FIFO
//   full (with no simultaneous pop) is dropped and latches the sticky
//   overflow flag.
//
// Input path
//   There is one holding register per CPU input port. A producer loads these
//   registers through s_valid/s_ready, and the CPU consumes them with in_ack.
//   Each register has a full flag, which the CPU sees on ine_pN.
//
// Timer
//   i_timer is a one-cycle interrupt pulse that fires every TIMER_PERIOD
//   enabled cycles.
//
// Ports
//   clk, reset                    clock (rising edge), async active-low reset
//   we_o, io_port, out_p0..3      CPU output-port write
//   m_valid, m_ready, m_port,
//   m_data                        capture FIFO head, to the consumer
//   overflow, ovf_clr             sticky dropped-write flag and its clear
//   s_valid, s_port, s_data,
//   s_ready                       producer side of the input registers
//   in_ack, in_ack_port           CPU consumed an input byte
//   in_p0..3, ine_p0..3           input bytes and {7'b0, full} flags, to the CPU
//   timer_en, i_timer             timer enable and interrupt pulse
module io_port_responder #(
  parameter int FIFO_DEPTH   = 8,
  parameter int TIMER_PERIOD = 1000,
  parameter int TW           = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       we_o,
  input  logic [1:0] io_port,
  input  logic [7:0] out_p0,
  input  logic [7:0] out_p1,
  input  logic [7:0] out_p2,
  input  logic [7:0] out_p3,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [1:0] m_port,
  output logic [7:0] m_data,
  output logic       overflow,
  input  logic       ovf_clr,
  input  logic       s_valid,
  input  logic [1:0] s_port,
  input  logic [7:0] s_data,
  output logic       s_ready,
  input  logic       in_ack,
  input  logic [1:0] in_ack_port,
  output logic [7:0] in_p0,
  output logic [7:0] in_p1,
  output logic [7:0] in_p2,
  output logic [7:0] in_p3,
  output logic [7:0] ine_p0,
  output logic [7:0] ine_p1,
  output logic [7:0] ine_p2,
  output logic [7:0] ine_p3,
  input  logic       timer_en,
  output logic       i_timer
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [TW-1:0] LAST_C  = TW'(TIMER_PERIOD - 1);

  // ---------------------------------------------------------------------------
  // Capture FIFO
  // ---------------------------------------------------------------------------
  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [7:0]    out_sel;
  logic [9:0]    head;
  logic          fifo_full;
  logic          do_pop;
  logic          do_push;
  logic          drop;

  always_comb begin
    out_sel = out_p0;
    case (io_port)
      2'd0: out_sel = out_p0;
      2'd1: out_sel = out_p1;
      2'd2: out_sel = out_p2;
      2'd3: out_sel = out_p3;
      default: out_sel = out_p0;
    endcase
  end

  // A pop in the same cycle frees a slot, so a write while full is still
  // accepted when the consumer is draining.
  assign fifo_full = (count == DEPTH_C);
  assign m_valid   = (count != '0);
  assign do_pop    = m_valid && m_ready;
  assign do_push   = we_o && (!fifo_full || do_pop);
  assign drop      = we_o && fifo_full && !do_pop;

  // Head entry is forced to zero while empty so stale data never shows.
  assign head   = mem[rd_ptr];
  assign m_port = m_valid ? head[9:8] : 2'd0;
  assign m_data = m_valid ? head[7:0] : 8'd0;

  // Storage has no reset; the pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= {io_port, out_sel};
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Setting the flag takes priority over clearing it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Input holding registers
  // ---------------------------------------------------------------------------
  logic [7:0] in_reg [4];
  logic [3:0] full_q;
  logic       load;

  // s_ready comes from the pre-ack state, so an ack and a load that target
  // the same port in one cycle refuse the load; the producer retries.
  assign s_ready = !full_q[s_port];
  assign load    = s_valid && s_ready;

  // The ack clear is written first, so a load to the same (empty) port wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full_q <= '0;
      for (int i = 0; i < 4; i++) begin
        in_reg[i] <= '0;
      end
    end else begin
      if (in_ack) begin
        full_q[in_ack_port] <= 1'b0;
      end
      if (load) begin
        full_q[s_port] <= 1'b1;
        in_reg[s_port] <= s_data;
      end
    end
  end

  assign in_p0  = in_reg[0];
  assign in_p1  = in_reg[1];
  assign in_p2  = in_reg[2];
  assign in_p3  = in_reg[3];
  assign ine_p0 = {7'b0, full_q[0]};
  assign ine_p1 = {7'b0, full_q[1]};
  assign ine_p2 = {7'b0, full_q[2]};
  assign ine_p3 = {7'b0, full_q[3]};

  // ---------------------------------------------------------------------------
  // Periodic timer
  // ---------------------------------------------------------------------------
  logic [TW-1:0] tcount;
  logic          tick_q;

  // The pulse is registered when the count wraps. The count simply holds
  // while the timer is disabled, so re-enabling resumes mid-period.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tcount <= '0;
      tick_q <= 1'b0;
    end else if (timer_en) begin
      if (tcount == LAST_C) begin
        tcount <= '0;
        tick_q <= 1'b1;
      end else begin
        tcount <= tcount + TW'(1);
        tick_q <= 1'b0;
      end
    end else begin
      tick_q <= 1'b0;
    end
  end

  // Gating with timer_en makes disable take effect on the output at once.
  assign i_timer = tick_q && timer_en;

endmodule
